// File: rtl/data_reg_pkg.sv
// Shared defaults and sizing helpers for the data register queue.
package data_reg_pkg;

    localparam int DEF_WIDTH = 14;
    localparam int DEF_DEPTH = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/data_reg_queue_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear.
module data_reg_queue_ptr
    import data_reg_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/data_reg_queue.sv
// First-word-fall-through register queue with sticky overflow flag.
// Optional per-entry even parity: define DATA_REG_QUEUE_PARITY_EN.
module data_reg_queue
    import data_reg_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = cnt_w(DEPTH),
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             par_err
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [PW-1:0]    w_rd;
    logic [PW-1:0]    w_wr;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign out_data  = r_mem[w_rd];

    // flush wins over any handshake in the same cycle
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    data_reg_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush),
        .i_inc   (w_push),
        .o_ptr   (w_wr)
    );

    data_reg_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush),
        .i_inc   (w_pop),
        .o_ptr   (w_rd)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
        end
    end

    // a rejected push outranks a clear request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DATA_REG_QUEUE_PARITY_EN
    logic r_par [DEPTH];
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_par[w_wr] <= ^in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_pop && ((^r_mem[w_rd]) != r_par[w_rd]);
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_reg_queue.sv
// Scoreboard bench for data_reg_queue: directed scenarios then random traffic.
module tb_data_reg_queue;

    localparam int W = 14;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   count;
    logic         overflow;
    logic         ovf_clr = 1'b0;
    logic         par_err;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] model [$];
    logic         ovf_m = 1'b0;
    logic         par_exp = 1'b0;

    data_reg_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check registered state, update the model.
    task automatic cyc(input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl,
                       input logic clr);
        @(negedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        ovf_clr   = clr;
        #1;
        chk("count", 64'(count), 64'(model.size()));
        chk("in_ready", 64'(in_ready), 64'(model.size() != D));
        chk("out_valid", 64'(out_valid), 64'(model.size() != 0));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("par_err", 64'(par_err), 64'(par_exp));
        if (iv && model.size() == D) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (fl) model.delete();
        else if (iv && model.size() < D) model.push_back(d);
    endtask

    // Monitor: every accepted pop must match the oldest modelled word.
    always @(negedge clk) begin
        #3;
        if (reset_n && !flush && out_valid && out_ready) begin
            if (model.size() == 0) begin
                chk("pop_on_empty", 64'(out_valid), 64'(0));
            end else begin
                chk("pop_data", 64'(out_data), 64'(model.pop_front()));
            end
        end
    end

    initial begin
        #2;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_par_err", 64'(par_err), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // fill, then overflow with a dropped word
        for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("ovf_set", 64'(overflow), 64'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // drain in order
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("drained_count", 64'(count), 64'(0));

        // streaming at count=2 across pointer wrap
        cyc(1'b1, 14'h0100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h0101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, W'(14'h0102 + i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("stream_count", 64'(count), 64'(2));
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // flush with simultaneous push at count=3, overflow held set
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(14'h0200 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 14'h02AA, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_keeps_ovf", 64'(overflow), 64'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-stream at count=2
        cyc(1'b1, 14'h0301, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h0302, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        model.delete();
        ovf_m = 1'b0;
        #2;
        reset_n = 1'b1;
        cyc(1'b1, 14'h1234, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_empty", 64'(count), 64'(0));

`ifdef DATA_REG_QUEUE_PARITY_EN
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 14'h0AAA, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        dut.r_mem[0] = 14'h0AAB;
        model[0]     = 14'h0AAB;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        #1;
        chk("par_pre", 64'(par_err), 64'(0));
        par_exp = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        par_exp = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, W'($urandom),
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < D + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("final_count", 64'(count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_reg_queue.md
DATA_REG_QUEUE -- requirements
Module: data_reg_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 14, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (2..64; not required to be a power of two).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous empty request.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  queue accepts a word this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  write word.
REQ-009 SHALL have port out_valid  output  1  out_data holds the oldest entry.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-011 SHALL have port out_data  output  WIDTH  head entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: push attempted while full.
REQ-014 SHALL have port ovf_clr  input  1  clears overflow.
REQ-015 SHALL have port par_err  output  1  parity mismatch on the popped word.

Function
REQ-016 SHALL push when in_valid && in_ready and pop when out_valid && out_ready, both at the rising clk edge.
REQ-017 SHALL drive in_ready = (count != DEPTH) and out_valid = (count != 0), combinationally from registered state only.
REQ-018 SHALL be first-word-fall-through: a word pushed into an empty queue appears on out_data with out_valid=1 one cycle after the push edge, with no combinational in-to-out path.
REQ-019 SHALL keep count unchanged on a simultaneous push and pop, and SHALL increment or decrement it by 1 on a push-only or pop-only cycle respectively.
REQ-020 SHALL, when full, leave in_ready=0 even if out_ready=1 in the same cycle; no pass-through push at full.
REQ-021 SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush=1, zero both pointers and count at the next edge, ignoring any push or pop in that cycle; storage contents need not be cleared.
REQ-024 SHALL set overflow on any cycle with in_valid=1 && in_ready=0; the set takes priority over a simultaneous ovf_clr; flush SHALL NOT clear overflow.
REQ-025 SHALL leave out_data undefined-but-stable (the last head value) while out_valid=0; benches must not check it.

Reset
REQ-026 SHALL, on reset_n low, immediately force pointers=0, count=0, overflow=0, and par_err=0, giving out_valid=0 and in_ready=1.
REQ-027 SHALL, when reset is asserted mid-transfer, discard all entries; the first post-reset push is the only valid content.
REQ-028 SHALL NOT reset the storage array.

Configuration
REQ-029 SHALL, with DATA_REG_QUEUE_PARITY_EN defined, store one even-parity bit per entry computed at push, and assert par_err for one cycle after any pop whose recomputed parity mismatches.
REQ-030 SHALL, without DATA_REG_QUEUE_PARITY_EN, keep the par_err port and tie it to 0, and store no parity bits.

Structure
REQ-031 SHALL take the WIDTH/DEPTH defaults and the count-width function from shared package data_reg_pkg.
REQ-032 SHALL implement each pointer as an instance of sub-module data_reg_queue_ptr (wrapping modulo-DEPTH counter with increment and clear).

Verification (WIDTH=14, DEPTH=4)
REQ-033 SHALL cover: after reset, push 0x0001..0x0004 with out_ready=0 -> count=4, in_ready=0; push 0x3FFF -> overflow=1, word dropped.
REQ-034 SHALL cover: drain the full queue -> pops 0x0001,0x0002,0x0003,0x0004 in order, then out_valid=0, count=0.
REQ-035 SHALL cover: with count=2, hold in_valid=out_ready=1 for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
REQ-036 SHALL cover: flush asserted with a simultaneous push at count=3 -> count=0 next cycle, out_valid=0, overflow unchanged.
REQ-037 SHALL cover: reset_n dropped mid-stream at count=2 -> count=0 immediately; the next push of 0x1234 is the only word popped.
REQ-038 SHALL cover, with parity enabled: force one stored bit flip on entry 0 holding 0x0AAA -> par_err=1 for exactly one cycle after its pop.
